// File: rtl/pipe_shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift mode encoding
// and the rule that spreads log-shift levels across register stages.
package pipe_shift_pkg;

  typedef enum logic [1:0] {
    LSR = 2'd0,
    ASR = 2'd1,
    LSL = 2'd2,
    ROR = 2'd3
  } shift_mode_t;

  // Index of the first shift level handled by a stage; stage 'stages' gives
  // the level count, so consecutive calls bound each stage's level range.
  function automatic int first_level(input int stage, input int levels, input int stages);
    return (stage * levels) / stages;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One 2^K level of the log shifter. When enabled it shifts by 2^K in the
// requested mode and reports whether any set bit fell off the LSB end
// (right shifts only); when disabled the data passes through untouched.
module shift_level
  import pipe_shift_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  shift_mode_t      mode,
  output logic [WIDTH-1:0] dout,
  output logic             sticky
);

  // K is always below clog2(WIDTH), so S < WIDTH and every slice is legal.
  localparam int S = 1 << K;

  logic signed [WIDTH-1:0] sdin;

  assign sdin = din;

  // Shift by 2^K in the selected mode and collect the dropped low bits.
  always_comb begin
    dout   = din;
    sticky = 1'b0;
    if (en) begin
      unique case (mode)
        LSR: begin
          dout   = din >> S;
          sticky = |din[S-1:0];
        end
        ASR: begin
          dout   = sdin >>> S;
          sticky = |din[S-1:0];
        end
        LSL: dout = din << S;
        ROR: dout = (din >> S) | (din << (WIDTH - S));
        default: dout = din;
      endcase
    end
  end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter with valid/ready on both sides. The clog2(WIDTH)
// shift levels are spread across PIPE register stages; the last stage drives
// the registered outputs. A sticky bit collects every bit lost by right
// shifts, and a sideband tag rides along with each request.
module pipe_barrel_shifter
  import pipe_shift_pkg::*;
#(
  parameter  int WIDTH   = 24,
  parameter  int PIPE    = 2,
  parameter  int TAG_W   = 4,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_amt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky,
  output logic               out_zero,
  output logic [TAG_W-1:0]   out_tag
);

  // Stage-input view: element s is what stage s's levels operate on.
  logic [WIDTH-1:0]   st_data   [PIPE];
  logic [SHIFT_W-1:0] st_amt    [PIPE];
  shift_mode_t        st_mode   [PIPE];
  logic [TAG_W-1:0]   st_tag    [PIPE];
  logic               st_sticky [PIPE];
  logic               st_vld    [PIPE];

  logic [PIPE-1:0] vld_p;
  logic [PIPE-1:0] ld;
  logic            room;

  assign st_data[0]   = in_data;
  assign st_amt[0]    = in_amt;
  assign st_mode[0]   = shift_mode_t'(in_mode);
  assign st_tag[0]    = in_tag;
  assign st_sticky[0] = 1'b0;
  assign st_vld[0]    = in_valid;

  // A stage loads when it or any stage downstream is empty, or the consumer takes the result.
  always_comb begin
    room = out_ready;
    ld   = '0;
    for (int s = PIPE - 1; s >= 0; s--) begin
      room  = room | ~vld_p[s];
      ld[s] = room;
    end
  end

  assign in_ready  = ld[0] & ~rst;
  assign out_valid = vld_p[PIPE-1];
  assign out_zero  = (out_data == '0);

  for (genvar s = 0; s < PIPE; s++) begin : g_stage
    localparam int LO   = first_level(s, SHIFT_W, PIPE);
    localparam int NLVL = first_level(s + 1, SHIFT_W, PIPE) - LO;

    // ---- stage s: combinational levels LO .. LO+NLVL-1 ----
    for (genvar j = 0; j < NLVL; j++) begin : g_lvl
      logic [WIDTH-1:0] din;
      logic [WIDTH-1:0] dout;
      logic             sin;
      logic             drop;
      logic             sout;

      if (j == 0) begin : g_head
        assign din = st_data[s];
        assign sin = st_sticky[s];
      end else begin : g_chain
        assign din = g_lvl[j-1].dout;
        assign sin = g_lvl[j-1].sout;
      end

      shift_level #(
        .WIDTH (WIDTH),
        .K     (LO + j)
      ) u_level (
        .din    (din),
        .en     (st_amt[s][LO+j]),
        .mode   (st_mode[s]),
        .dout   (dout),
        .sticky (drop)
      );

      assign sout = sin | drop;
    end

    logic [WIDTH-1:0] res;
    logic             res_sticky;
    logic             vld_q;

    assign res        = g_lvl[NLVL-1].dout;
    assign res_sticky = g_lvl[NLVL-1].sout;
    assign vld_p[s]   = vld_q;

    // ---- stage s register boundary ----
    // Occupancy flag: refilled from upstream whenever this stage loads.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
      end else if (ld[s]) begin
        vld_q <= st_vld[s];
      end
    end

    if (s < PIPE - 1) begin : g_mid
      logic [WIDTH-1:0]   data_q;
      logic [SHIFT_W-1:0] amt_q;
      shift_mode_t        mode_q;
      logic [TAG_W-1:0]   tag_q;
      logic               sticky_q;

      // Capture the partial result only for real items; bubbles leave it alone.
      always_ff @(posedge clk) begin
        if (ld[s] && st_vld[s]) begin
          data_q   <= res;
          amt_q    <= st_amt[s];
          mode_q   <= st_mode[s];
          tag_q    <= st_tag[s];
          sticky_q <= res_sticky;
        end
      end

      assign st_data[s+1]   = data_q;
      assign st_amt[s+1]    = amt_q;
      assign st_mode[s+1]   = mode_q;
      assign st_tag[s+1]    = tag_q;
      assign st_sticky[s+1] = sticky_q;
      assign st_vld[s+1]    = vld_q;
    end else begin : g_last
      logic [WIDTH-1:0] data_q;
      logic [TAG_W-1:0] tag_q;
      logic             sticky_q;

      // Output register: cleared by reset so the port reads zero while idle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_q   <= '0;
          tag_q    <= '0;
          sticky_q <= 1'b0;
        end else if (ld[s] && st_vld[s]) begin
          data_q   <= res;
          tag_q    <= st_tag[s];
          sticky_q <= res_sticky;
        end
      end

      assign out_data   = data_q;
      assign out_tag    = tag_q;
      assign out_sticky = sticky_q;
    end
  end

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter (WIDTH=24, PIPE=2).
module tb_pipe_barrel_shifter;

  localparam int W  = 24;
  localparam int TW = 4;
  localparam int SW = 5;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_amt;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_sticky;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  typedef struct packed {
    logic [W-1:0]  d;
    logic          s;
    logic [TW-1:0] t;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  logic          s_ovalid, s_iready, s_osticky, s_ozero;
  logic [W-1:0]  s_odata;
  logic          acc_last, prev_stall;
  logic [W-1:0]  h_data;
  logic          h_sticky, h_zero;
  logic [TW-1:0] h_tag;

  pipe_barrel_shifter #(
    .WIDTH (W),
    .PIPE  (2),
    .TAG_W (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_mode    (in_mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .out_zero   (out_zero),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: result of one request from the mode rules with plain arithmetic.
  function automatic exp_t model(input logic [W-1:0] d, input int a, input int m, input logic [TW-1:0] t);
    exp_t        e;
    logic [W-1:0] mask;
    logic [2*W-1:0] dd;
    int          r;
    e.t = t;
    e.s = 1'b0;
    e.d = '0;
    case (m)
      0, 1: begin
        if (a >= W) begin
          e.d = (m == 1 && d[W-1]) ? '1 : '0;
          e.s = |d;
        end else begin
          mask = (W'(1) << a) - W'(1);
          e.s  = |(d & mask);
          e.d  = (m == 1) ? W'($signed(d) >>> a) : (d >> a);
        end
      end
      2: e.d = (a >= W) ? '0 : (d << a);
      default: begin
        r   = (a >= W) ? a - W : a;
        dd  = {d, d} >> r;
        e.d = dd[W-1:0];
      end
    endcase
    return e;
  endfunction

  // Sample mid-cycle, score handshakes that will complete on the next edge.
  task automatic tick();
    exp_t e;
    #1;
    s_ovalid  = out_valid;
    s_iready  = in_ready;
    s_odata   = out_data;
    s_osticky = out_sticky;
    s_ozero   = out_zero;
    if (prev_stall) begin
      check("hold_vld", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(h_data));
      check("hold_sticky", 32'(out_sticky), 32'(h_sticky));
      check("hold_zero", 32'(out_zero), 32'(h_zero));
      check("hold_tag", 32'(out_tag), 32'(h_tag));
    end
    prev_stall = out_valid && !out_ready;
    h_data   = out_data;
    h_sticky = out_sticky;
    h_zero   = out_zero;
    h_tag    = out_tag;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_result", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("data", 32'(out_data), 32'(e.d));
        check("sticky", 32'(out_sticky), 32'(e.s));
        check("zero", 32'(out_zero), 32'(e.d == '0));
        check("tag", 32'(out_tag), 32'(e.t));
      end
    end
    acc_last = in_valid && in_ready;
    if (acc_last) sb.push_back(model(in_data, int'(in_amt), int'(in_mode), in_tag));
    @(negedge clk);
  endtask

  task automatic new_req(input int t);
    in_valid = 1'b1;
    in_data  = W'($urandom());
    in_amt   = SW'($urandom_range(0, 31));
    in_mode  = 2'($urandom_range(0, 3));
    in_tag   = TW'(t);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] d, input int a, input int m,
                          input logic [W-1:0] ed, input logic es);
    int lat;
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = SW'(a);
    in_mode   = 2'(m);
    in_tag    = TW'(a);
    out_ready = 1'b1;
    tick();
    check({tag, "_acc"}, 32'(acc_last), 32'd1);
    in_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!s_ovalid && lat < 6);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_data"}, 32'(s_odata), 32'(ed));
    check({tag, "_sticky"}, 32'(s_osticky), 32'(es));
    check({tag, "_zero"}, 32'(s_ozero), 32'(ed == '0));
  endtask

  task automatic drain();
    int guard;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int nacc;
    int k;
    int guard;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_amt     = '0;
    in_mode    = 2'd0;
    in_tag     = '0;
    out_ready  = 1'b1;
    prev_stall = 1'b0;
    acc_last   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sticky", 32'(out_sticky), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(s_iready), 32'd1);

    // Directed vectors
    directed("lsr1",  24'h800001, 1,  0, 24'h400000, 1'b1);
    directed("asr4",  24'h800000, 4,  1, 24'hF80000, 1'b0);
    directed("lsl22", 24'h000003, 22, 2, 24'hC00000, 1'b0);
    directed("ror1",  24'h000001, 1,  3, 24'h800000, 1'b0);
    directed("ror25", 24'h000001, 25, 3, 24'h800000, 1'b0);
    directed("lsr30", 24'h000010, 30, 0, 24'h000000, 1'b1);
    directed("asr31", 24'h812345, 31, 1, 24'hFFFFFF, 1'b1);
    directed("amt0",  24'hA5A5A5, 0,  1, 24'hA5A5A5, 1'b0);

    // Streaming: 8 back-to-back requests, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) new_req(i);
      else in_valid = 1'b0;
      tick();
      check("stream_vld", 32'(s_ovalid), 32'(i >= 2 && i < 10));
      if (i < 8) check("stream_rdy", 32'(s_iready), 32'd1);
    end

    // Backpressure: consumer stalls for 6 cycles
    out_ready = 1'b0;
    nacc = 0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || acc_last) begin
        new_req(8 + k);
        k++;
      end
      tick();
      if (acc_last) nacc++;
      check("bp_rdy", 32'(s_iready), 32'(i < 2));
    end
    check("bp_count", 32'(nacc), 32'd2);
    out_ready = 1'b1;
    guard = 0;
    while (nacc < 6 && guard < 20) begin
      tick();
      guard++;
      if (acc_last) begin
        nacc++;
        if (nacc < 6) begin
          new_req(8 + k);
          k++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("bp_all_accepted", 32'(nacc), 32'd6);
    drain();

    // Reset with two items in flight
    out_ready = 1'b0;
    new_req(1);
    tick();
    new_req(2);
    tick();
    in_valid = 1'b0;
    tick();
    check("inflight_vld", 32'(s_ovalid), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_zero", 32'(out_zero), 32'd1);
    check("midrst_out_data", 32'(out_data), 32'd0);
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("rel_in_ready", 32'(s_iready), 32'd1);
    check("no_stale", 32'(s_ovalid), 32'd0);
    repeat (4) begin
      tick();
      check("no_stale", 32'(s_ovalid), 32'd0);
    end

    // Randomised traffic with random backpressure
    in_valid = 1'b0;
    acc_last = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || acc_last) begin
        if ($urandom_range(0, 9) < 7) new_req(i);
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_barrel_shifter.md
PIPE_BARREL_SHIFTER -- requirements
Module: pipe_barrel_shifter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 24, giving the data width in bits (range 2..64).
REQ-002 The module SHALL have parameter PIPE, default 2, giving the number of register stages (range 1..SHIFT_W).
REQ-003 The module SHALL have parameter TAG_W, default 4, giving the width of the sideband tag.
REQ-004 The module SHALL derive SHIFT_W = clog2(WIDTH) as a local parameter.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-009 The module SHALL have port in_data, input, WIDTH bits: the operand.
REQ-010 The module SHALL have port in_amt, input, SHIFT_W bits: the shift amount.
REQ-011 The module SHALL have port in_mode, input, 2 bits: 0 = LSR, 1 = ASR, 2 = LSL, 3 = ROR.
REQ-012 The module SHALL have port in_tag, input, TAG_W bits: a sideband value passed through unmodified.
REQ-013 The module SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-014 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-015 The module SHALL have port out_data, output, WIDTH bits: the shifted result.
REQ-016 The module SHALL have port out_sticky, output, 1 bit: the OR of all bits shifted out (LSR/ASR only; 0 otherwise).
REQ-017 The module SHALL have port out_zero, output, 1 bit: out_data == 0.
REQ-018 The module SHALL have port out_tag, output, TAG_W bits: the tag of the request that produced this result.

Function
REQ-019 A transfer SHALL occur on any cycle where valid && ready is true, on each side independently.
REQ-020 The SHIFT_W log-shift levels SHALL be split over PIPE register stages as evenly as possible, with the last stage feeding registered outputs.
- Latency is exactly PIPE cycles from input transfer to out_valid when there is no backpressure.
REQ-021 Each stage SHALL advance when it is empty or its successor accepts; otherwise it holds data, amount, mode, tag and sticky.
- Throughput is 1 result/cycle; the block holds at most PIPE items in flight.
REQ-022 in_ready SHALL equal (stage 0 empty) OR (stage 0 advancing) in the same cycle (combinational path from out_ready permitted).
REQ-023 LSR SHALL zero-fill from the MSB, ASR SHALL fill with in_data[WIDTH-1], LSL SHALL zero-fill from the LSB, and ROR SHALL rotate toward the LSB.
REQ-024 When in_amt >= WIDTH: LSR/LSL SHALL give 0, ASR SHALL give all copies of the sign bit, the sticky SHALL equal the OR of in_data (LSR/ASR), and ROR SHALL use in_amt - WIDTH.
REQ-025 When in_amt == 0, out_data SHALL equal in_data and out_sticky SHALL be 0.
REQ-026 The sticky SHALL accumulate per level (OR of the bits dropped at that level) and be carried through the stages.
REQ-027 out_data, out_sticky, out_zero and out_tag SHALL remain stable while out_valid && !out_ready.
REQ-028 Results SHALL emerge in acceptance order; no request is dropped or duplicated.

Reset
REQ-029 While rst is high, all stage-valid flags, out_valid, out_data, out_sticky, out_tag SHALL be 0, out_zero SHALL be 1, and in_ready SHALL be 0.
REQ-030 A reset asserted mid-operation SHALL discard all in-flight items; the first cycle after deassertion SHALL have in_ready = 1.

Structure
REQ-031 The mode encoding (shift_mode_t enum: LSR, ASR, LSL, ROR) SHALL live in the shared package pipe_shift_pkg.
REQ-032 One sub-module, shift_level, SHALL implement a single 2^k level with its sticky contribution, parametrised by WIDTH and k, and be instantiated SHIFT_W times.

Verification (WIDTH=24, PIPE=2)
REQ-033 LSR 24'h800001, amt 1 -> out_data 24'h400000, sticky 1, out_valid exactly 2 cycles after acceptance.
REQ-034 ASR 24'h800000, amt 4 -> 24'hF80000, sticky 0; LSL 24'h000003, amt 22 -> 24'h C00000, sticky 0.
REQ-035 ROR 24'h000001, amt 1 -> 24'h800000; ROR 24'h000001, amt 25 -> 24'h800000; LSR 24'h000010, amt 30 -> 0, sticky 1, zero 1.
REQ-036 Streaming: 8 back-to-back requests (tags 0..7) with out_ready=1 -> 8 consecutive results in tag order, no bubbles.
REQ-037 Backpressure: out_ready=0 for 6 cycles while in_valid=1 -> exactly 2 accepted then in_ready=0; outputs stable; on release, order preserved and none lost.
REQ-038 Assert rst with 2 items in flight -> out_valid=0 immediately; no stale result appears after deassertion.
